// File: rtl/controller_pkg.sv
// Shared types and defaults for the slicer sequencer.
package controller_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIG, S_WAIT_ECHO, S_EVAL, S_CUT, S_PAUSED, S_DONE
  } state_e;

  typedef enum logic [1:0] {PH_HOME, PH_ADV, PH_RET} phase_e;

  localparam int unsigned DEF_SLICE_STEP = 300;
  localparam int unsigned DEF_HOME_TOL   = 20;
  localparam int unsigned DEF_TIMEOUT    = 3_000_000;

  // Index of the final cut; a request for 0 pieces behaves like 1.
  function automatic logic [4:0] last_cut(input logic [4:0] n);
    return (n == 5'd0) ? 5'd0 : n - 5'd1;
  endfunction

endpackage

// File: rtl/controller_echo_timer.sv
// Echo watchdog: counts cycles while not cleared, flags the final cycle of the window.
module controller_echo_timer
  import controller_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (clr_i)          cnt_q <= '0;
    else if (cnt_q != LAST)  cnt_q <= cnt_q + TW'(1);
  end

  assign expire_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/controller.sv
// Slicer sequencer: ranges the carriage, requests cuts every SLICE_STEP, returns home.
module controller
  import controller_pkg::*;
#(
  parameter int unsigned SLICE_STEP = DEF_SLICE_STEP,
  parameter int unsigned HOME_TOL   = DEF_HOME_TOL,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic [4:0]  slice_num,
  input  logic        valid,
  input  logic [31:0] distance,
  input  logic        triggerSuc,
  output logic        trigger,
  output logic        move,
  input  logic        cut_end,
  output logic        cut,
  output logic        finish
);

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [31:0] ref_q, ref_d, home_q, home_d, dist_q, dist_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        trigger_q, trigger_d, move_q, move_d, cut_q, cut_d, finish_q, finish_d;
  logic        expire;

  controller_echo_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != S_WAIT_ECHO),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    ref_d   = ref_q;
    home_d  = home_q;
    dist_d  = dist_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start) begin
        state_d = S_TRIG;
        phase_d = PH_HOME;
        cnt_d   = '0;
      end
      S_TRIG: begin
        if (pause)           state_d = S_PAUSED;
        else if (triggerSuc) state_d = S_WAIT_ECHO;
      end
      S_WAIT_ECHO: begin
        if (pause) state_d = S_PAUSED;
        else if (valid) begin
          dist_d  = distance;
          state_d = S_EVAL;
        end else if (expire) state_d = S_TRIG;
      end
      S_EVAL: begin
        if (pause) state_d = S_PAUSED;
        else begin
          state_d = S_TRIG;
          unique case (phase_q)
            PH_HOME: begin
              home_d  = dist_q;
              ref_d   = dist_q;
              phase_d = (slice_num <= 5'd1) ? PH_RET : PH_ADV;
            end
            PH_ADV: if (dist_q <= ref_q && (ref_q - dist_q) >= 32'(SLICE_STEP)) begin
              state_d = S_CUT;
              ref_d   = dist_q;
              cnt_d   = cnt_q + 5'd1;
            end
            // 33-bit sum so a reading near the top of range cannot wrap
            PH_RET: if (({1'b0, dist_q} + 33'(HOME_TOL)) >= {1'b0, home_q})
              state_d = S_DONE;
            default: state_d = S_TRIG;
          endcase
        end
      end
      S_CUT: if (cut_end) begin
        if (cnt_q == last_cut(slice_num)) phase_d = PH_RET;
        state_d = pause ? S_PAUSED : S_TRIG;
      end
      S_PAUSED: if (!pause) state_d = S_TRIG;
      default:  state_d = S_IDLE;
    endcase

    trigger_d = (state_d == S_TRIG);
    cut_d     = (state_d == S_CUT);
    finish_d  = (state_d == S_DONE);
    move_d    = (phase_d == PH_ADV) &&
                (state_d == S_TRIG || state_d == S_WAIT_ECHO || state_d == S_EVAL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      phase_q   <= PH_HOME;
      ref_q     <= '0;
      home_q    <= '0;
      dist_q    <= '0;
      cnt_q     <= '0;
      trigger_q <= 1'b0;
      move_q    <= 1'b0;
      cut_q     <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      ref_q     <= ref_d;
      home_q    <= home_d;
      dist_q    <= dist_d;
      cnt_q     <= cnt_d;
      trigger_q <= trigger_d;
      move_q    <= move_d;
      cut_q     <= cut_d;
      finish_q  <= finish_d;
    end
  end

  assign trigger = trigger_q;
  assign move    = move_q;
  assign cut     = cut_q;
  assign finish  = finish_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller; cut/finish rising edges are checked against an event queue.
module tb_controller;

  localparam int TO = 50;
  localparam int EV_CUT = 1, EV_FIN = 2;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        start = 1'b0, pause = 1'b0, valid = 1'b0, triggerSuc = 1'b0, cut_end = 1'b0;
  logic [4:0]  slice_num = 5'd0;
  logic [31:0] distance = '0;
  logic        trigger, move, cut, finish;
  logic        cut_prev = 1'b0, fin_prev = 1'b0;

  int n_chk = 0, n_pass = 0;
  int exp_q[$];

  controller #(.SLICE_STEP(300), .HOME_TOL(20), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .slice_num(slice_num),
    .valid(valid), .distance(distance), .triggerSuc(triggerSuc), .trigger(trigger),
    .move(move), .cut_end(cut_end), .cut(cut), .finish(finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full measurement: wait for trigger, accept it, return distance d.
  task automatic meas(input logic [31:0] d);
    for (int i = 0; i < 100 && !trigger; i++) step();
    chk("trig_wait", trigger, 1);
    triggerSuc = 1'b1; step();
    triggerSuc = 1'b0; valid = 1'b1; distance = d; step();
    valid = 1'b0; step();
  endtask

  task automatic ev(input int code);
    if (exp_q.size() == 0) chk("ev_unexpected", code, 0);
    else chk("ev_order", code, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cut && !cut_prev)    ev(EV_CUT);
      if (finish && !fin_prev) ev(EV_FIN);
    end
    cut_prev <= cut;
    fin_prev <= finish;
  end

  initial begin
    step(3);
    chk("rst_trigger", trigger, 0);
    chk("rst_move", move, 0);
    chk("rst_cut", cut, 0);
    chk("rst_finish", finish, 0);
    rst_n = 1'b1; pause = 1'b1; step(2);
    chk("idle_pause_ignored", trigger, 0);
    pause = 1'b0;

    // Job with 3 pieces: home measurement
    start = 1'b1; slice_num = 5'd3; step();
    start = 1'b0;
    chk("start_trigger", trigger, 1);
    chk("home_move", move, 0);
    step(2);
    chk("trigger_held", trigger, 1);
    meas(900);
    chk("adv_trigger", trigger, 1);
    chk("adv_move", move, 1);

    // Pause in WAIT_ECHO, then a short second pause
    triggerSuc = 1'b1; step(); triggerSuc = 1'b0;
    chk("wait_move", move, 1);
    pause = 1'b1; step();
    chk("pause_trigger", trigger, 0);
    chk("pause_move", move, 0);
    step(9);
    chk("pause_hold", trigger | move, 0);
    pause = 1'b0; step();
    chk("resume_trigger", trigger, 1);
    triggerSuc = 1'b1; step(); triggerSuc = 1'b0; step();
    pause = 1'b1; step();
    chk("pause2_trigger", trigger, 0);
    pause = 1'b0; step();
    chk("resume2_trigger", trigger, 1);

    // First cut at exactly SLICE_STEP
    exp_q.push_back(EV_CUT);
    meas(600);
    chk("cut1", cut, 1);
    chk("cut1_move", move, 0);
    step(9);
    chk("cut1_held", cut, 1);
    cut_end = 1'b1; step(); cut_end = 1'b0;
    chk("cut1_done", cut, 0);
    chk("cut1_move_back", move, 1);

    meas(450);
    chk("no_cut_450", cut, 0);
    chk("no_cut_trig", trigger, 1);
    meas(700);
    chk("farther_no_cut", cut, 0);

    // Second (last) cut, pause held across cut_end
    exp_q.push_back(EV_CUT);
    meas(280);
    chk("cut2", cut, 1);
    pause = 1'b1; step(3);
    chk("cut2_not_paused", cut, 1);
    cut_end = 1'b1; step(); cut_end = 1'b0;
    chk("cut2_to_paused", trigger | cut, 0);
    pause = 1'b0; step();
    chk("ret_trigger", trigger, 1);
    chk("ret_move", move, 0);

    meas(500);
    chk("ret_500", finish, 0);
    meas(740);
    chk("ret_740", finish, 0);
    chk("ret_740_trig", trigger, 1);
    exp_q.push_back(EV_FIN);
    meas(910);
    chk("finish", finish, 1);
    step(5);
    chk("finish_held", finish, 1);
    chk("done_trigger", trigger, 0);

    // slice_num=1: no cuts, timeout re-trigger, tolerance boundary
    start = 1'b1; slice_num = 5'd1; step();
    start = 1'b0;
    chk("restart_finish", finish, 0);
    meas(500);
    chk("ret1_move", move, 0);
    triggerSuc = 1'b1; step(); triggerSuc = 1'b0;
    step(TO - 1);
    chk("timeout_not_yet", trigger, 0);
    step();
    chk("timeout_retrig", trigger, 1);
    meas(479);
    chk("tol_below", finish, 0);
    exp_q.push_back(EV_FIN);
    meas(480);
    chk("tol_edge_finish", finish, 1);

    step(2);
    chk("ev_pending", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
